// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM states, {cpol,cpha} mode codes and a
// width helper that never returns zero.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        NEXT,
        HOLD
    } spi_state_e;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with a count register for full/empty. SHOW_AHEAD=1 exposes
// the head word combinationally instead of a registered pop result.
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter bit SHOW_AHEAD = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    generate
        if (SHOW_AHEAD) begin : g_show_ahead
            assign dout_o = mem_q[rd_ptr_q];
        end else begin : g_registered
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk_i) begin
                if (rst_i)       dout_q <= '0;
                else if (do_pop) dout_q <= mem_q[rd_ptr_q];
            end
            assign dout_o = dout_q;
        end
    endgenerate

endmodule

// File: rtl/spi_master_fifo.sv
// SPI master that sends the whole TX FIFO as one chip-select burst in any of
// the four CPOL/CPHA modes and queues every received word in the RX FIFO.
module spi_master_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int CLK_DIV = 2,
    parameter int NUM_CS  = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           enable_i,
    input  logic                           write_i,
    input  logic [DATA_W-1:0]              data_i,
    input  logic                           read_i,
    output logic [DATA_W-1:0]              out_o,
    input  logic                           strans_i,
    input  logic                           cpol_i,
    input  logic                           cpha_i,
    input  logic [clog2_min1(NUM_CS)-1:0]  cs_sel_i,
    input  logic                           miso_i,
    output logic                           mosi_o,
    output logic                           mclk_o,
    output logic [NUM_CS-1:0]              cs_o,
    output logic                           busy_o,
    output logic                           tx_full_o,
    output logic                           tx_empty_o,
    output logic                           rx_empty_o,
    output logic                           rx_ovf_o
);

    localparam int                DIV_W     = clog2_min1(CLK_DIV);
    localparam int                HALF_W    = clog2_min1(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic [HALF_W-1:0] half_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic [1:0]        mode_q;
    logic              mclk_q;
    logic              mosi_q;
    logic              rx_ovf_q;
    logic [NUM_CS-1:0] cs_q;

    logic [DATA_W-1:0] tx_head;
    logic [DATA_W-1:0] tx_shifted;
    logic              tx_pop;
    logic              rx_push;
    logic              rx_full;
    logic              start;
    logic              load_word;
    logic              load_cpha;
    logic              half_end;
    logic              cpha_lat;
    logic              shift_edge;
    logic              shift_tick;

    // The shifter needs the head word on the same edge it is popped, so TX is show-ahead
    spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH), .SHOW_AHEAD(1'b1)) u_tx_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (write_i),
        .din_i  (data_i),
        .pop_i  (tx_pop),
        .dout_o (tx_head),
        .full_o (tx_full_o),
        .empty_o(tx_empty_o)
    );

    spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH), .SHOW_AHEAD(1'b0)) u_rx_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (rx_push),
        .din_i  (rx_sh_q),
        .pop_i  (read_i),
        .dout_o (out_o),
        .full_o (rx_full),
        .empty_o(rx_empty_o)
    );

    assign half_end   = (div_q == DIV_LAST);
    assign cpha_lat   = (mode_q == MODE1) || (mode_q == MODE3);
    assign shift_edge = (!half_q[0]) == cpha_lat;
    assign shift_tick = (state_q == SHIFT) && half_end;
    assign tx_shifted = tx_sh_q << 1;
    assign load_cpha  = start ? cpha_i : cpha_lat;

    always_comb begin
        state_d   = state_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        start     = 1'b0;
        load_word = 1'b0;
        case (state_q)
            IDLE: begin
                if (strans_i && enable_i && !tx_empty_o) begin
                    state_d   = SETUP;
                    tx_pop    = 1'b1;
                    start     = 1'b1;
                    load_word = 1'b1;
                end
            end
            SETUP: if (half_end) state_d = SHIFT;
            SHIFT: if (half_end && (half_q == HALF_LAST)) state_d = NEXT;
            NEXT: begin
                rx_push = 1'b1;
                if (!tx_empty_o && enable_i) begin
                    state_d   = SHIFT;
                    tx_pop    = 1'b1;
                    load_word = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD:    if (half_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            div_q    <= '0;
            half_q   <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            mode_q   <= MODE0;
            mclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_q     <= '1;
            rx_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q || half_end)
                div_q <= '0;
            else if (state_q != IDLE)
                div_q <= div_q + 1'b1;

            if (load_word)       half_q <= '0;
            else if (shift_tick) half_q <= half_q + 1'b1;

            if (start) begin
                mode_q <= {cpol_i, cpha_i};
                mclk_q <= cpol_i;
                cs_q   <= ~(NUM_CS'(1) << cs_sel_i);
            end else if (shift_tick) begin
                mclk_q <= ~mclk_q;
            end else if (state_q == HOLD && half_end) begin
                cs_q <= '1;
            end

            // CPHA=0 presents the MSB before the first edge; CPHA=1 waits for the leading edge
            if (load_word) begin
                tx_sh_q <= tx_head;
                if (!load_cpha) mosi_q <= tx_head[DATA_W-1];
            end else if (shift_tick && shift_edge) begin
                tx_sh_q <= tx_shifted;
                mosi_q  <= cpha_lat ? tx_sh_q[DATA_W-1] : tx_shifted[DATA_W-1];
            end

            if (shift_tick && !shift_edge) rx_sh_q <= DATA_W'({rx_sh_q, miso_i});

            if (rx_push && rx_full) rx_ovf_q <= 1'b1;
        end
    end

    assign mclk_o   = mclk_q;
    assign mosi_o   = mosi_q;
    assign cs_o     = cs_q;
    assign busy_o   = (state_q != IDLE);
    assign rx_ovf_o = rx_ovf_q;

endmodule
